// File: rtl/ibex_multdiv_pkg.sv
// Shared types and op-class helpers for the iterative multiply/divide unit.
package ibex_multdiv_pkg;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_ITER = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  function automatic logic is_div(md_op_e op);
    return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
  endfunction

  function automatic logic is_rem(md_op_e op);
    return op inside {MD_OP_REM, MD_OP_REMU};
  endfunction

  function automatic logic is_high(md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU};
  endfunction

  function automatic logic a_signed(md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
  endfunction

  function automatic logic b_signed(md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
  endfunction

endpackage

// File: rtl/ibex_md_mul_step.sv
// One multiply iteration: adds mag_a times the low MUL_BITS of mb into acc,
// then shifts {acc, mb} right by MUL_BITS.
module ibex_md_mul_step
  import ibex_multdiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 4
) (
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mb,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mb_next
);

  localparam int SW = WIDTH + MUL_BITS;

  logic [SW-1:0] pp [MUL_BITS];
  logic [SW-1:0] sum;

  for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
    assign pp[gi] = mb[gi] ? ({{MUL_BITS{1'b0}}, mag_a} << gi) : '0;
  end

  // acc < 2^W on entry, so the sum never exceeds W+MUL_BITS bits.
  always_comb begin
    sum = {{MUL_BITS{1'b0}}, acc};
    for (int i = 0; i < MUL_BITS; i++) begin
      sum = sum + pp[i];
    end
  end

  assign acc_next = sum[SW-1:MUL_BITS];
  assign mb_next  = {sum[MUL_BITS-1:0], mb[WIDTH-1:MUL_BITS]};

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes,
// divide early-outs, kill and a data-independent-timing mode.
module ibex_multdiv_iter
  import ibex_multdiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  md_state_e        state_reg, state_next;
  md_op_e           op_reg;
  logic             sa_reg, sb_reg, dit_reg, bz_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH-1:0] mb_reg, mag_reg, result_reg;
  logic [CW-1:0]    cnt_reg;

  // Between accept and PREP, mb_reg holds raw a and mag_reg holds raw b.
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             b_zero, early;
  logic [WIDTH-1:0] early_res;

  assign abs_a     = sa_reg ? -mb_reg : mb_reg;
  assign abs_b     = sb_reg ? -mag_reg : mag_reg;
  assign b_zero    = (mag_reg == '0);
  assign early     = is_div(op_reg) & ~dit_reg & (b_zero | (abs_a < abs_b));
  assign early_res = is_rem(op_reg) ? mb_reg : (b_zero ? '1 : '0);

  logic [WIDTH-1:0] mul_acc, mul_mb;

  ibex_md_mul_step #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul_step (
    .mag_a    (mag_reg),
    .acc      (acc_reg[WIDTH-1:0]),
    .mb       (mb_reg),
    .acc_next (mul_acc),
    .mb_next  (mul_mb)
  );

  // Restoring divide step on {rem, quo}; the remainder stays below 2^W.
  logic [WIDTH:0]   rem_sh, rem_nx;
  logic             rem_ge;
  logic [WIDTH-1:0] quo_nx;
  logic             unused_acc_msb;

  assign rem_sh         = {acc_reg[WIDTH-1:0], mb_reg[WIDTH-1]};
  assign rem_ge         = (rem_sh >= {1'b0, mag_reg});
  assign rem_nx         = rem_ge ? (rem_sh - {1'b0, mag_reg}) : rem_sh;
  assign quo_nx         = {mb_reg[WIDTH-2:0], rem_ge};
  assign unused_acc_msb = acc_reg[WIDTH];

  logic [2*WIDTH-1:0] prod, prod_fx;
  logic [WIDTH-1:0]   quo_fx, rem_fx, fix_res;

  assign prod    = {acc_reg[WIDTH-1:0], mb_reg};
  assign prod_fx = (sa_reg ^ sb_reg) ? -prod : prod;
  assign quo_fx  = (sa_reg ^ sb_reg) & ~bz_reg ? -mb_reg : mb_reg;
  assign rem_fx  = sa_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign fix_res = is_div(op_reg)  ? (is_rem(op_reg) ? rem_fx : quo_fx) :
                   is_high(op_reg) ? prod_fx[2*WIDTH-1:WIDTH] : prod_fx[WIDTH-1:0];

  logic [CW-1:0] iter_last;
  assign iter_last = is_div(op_reg) ? DIV_LAST : MUL_LAST;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: if (in_valid_i) state_next = MD_PREP;
      MD_PREP: state_next = early ? MD_DONE : MD_ITER;
      MD_ITER: if (cnt_reg == iter_last) state_next = MD_FIX;
      MD_FIX:  state_next = MD_DONE;
      MD_DONE: if (out_ready_i) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (kill_i && (state_reg != MD_IDLE)) state_next = MD_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= MD_IDLE;
      op_reg     <= MD_OP_MUL;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      dit_reg    <= 1'b0;
      bz_reg     <= 1'b0;
      acc_reg    <= '0;
      mb_reg     <= '0;
      mag_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        MD_IDLE: begin
          if (in_valid_i) begin
            op_reg  <= md_op_e'(op_i);
            sa_reg  <= a_signed(md_op_e'(op_i)) & op_a_i[WIDTH-1];
            sb_reg  <= b_signed(md_op_e'(op_i)) & op_b_i[WIDTH-1];
            dit_reg <= data_ind_timing_i;
            mb_reg  <= op_a_i;
            mag_reg <= op_b_i;
          end
        end
        MD_PREP: begin
          acc_reg <= '0;
          cnt_reg <= '0;
          bz_reg  <= b_zero;
          // Divide keeps |a| in the quotient slot; multiply streams |b| out of mb.
          if (is_div(op_reg)) begin
            mb_reg  <= abs_a;
            mag_reg <= abs_b;
          end else begin
            mb_reg  <= abs_b;
            mag_reg <= abs_a;
          end
          if (early) result_reg <= early_res;
        end
        MD_ITER: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (is_div(op_reg)) begin
            acc_reg <= rem_nx;
            mb_reg  <= quo_nx;
          end else begin
            acc_reg <= {1'b0, mul_acc};
            mb_reg  <= mul_mb;
          end
        end
        MD_FIX:  result_reg <= fix_res;
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_reg == MD_IDLE);
  assign out_valid_o = (state_reg == MD_DONE);
  assign result_o    = result_reg;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Randomised and directed bench for ibex_multdiv_iter against an RV-M arithmetic model.
module tb_ibex_multdiv_iter;

  localparam int W       = 32;
  localparam int MB      = 4;
  localparam int MUL_LAT = 3 + W / MB;
  localparam int DIV_LAT = 3 + W;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op_in = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         dit = 1'b0;
  logic         kill = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ibex_multdiv_iter #(
    .WIDTH    (W),
    .MUL_BITS (MB)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .op_i              (op_in),
    .op_a_i            (op_a),
    .op_b_i            (op_b),
    .data_ind_timing_i (dit),
    .kill_i            (kill),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .result_o          (result)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics expressed with plain arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W+1:0]      ax, bx, p;
    logic signed [W-1:0] as_v, bs_v;
    logic [W-1:0]        min_v, ones;
    min_v = '0;
    min_v[W-1] = 1'b1;
    ones = '1;
    as_v = a;
    bs_v = b;
    ax = (op == OP_MULH || op == OP_MULHSU) ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    bx = (op == OP_MULH) ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p  = ax * bx;
    case (op)
      OP_MUL:                        return p[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  return p[2*W-1:W];
      OP_DIV: begin
        if (b == '0) return ones;
        if (a == min_v && b == ones) return min_v;
        return as_v / bs_v;
      end
      OP_DIVU:  return (b == '0) ? ones : a / b;
      OP_REM: begin
        if (b == '0) return a;
        if (a == min_v && b == ones) return '0;
        return as_v % bs_v;
      end
      default:  return (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       begin v = '0; v[W-1] = 1'b1; end
      3:       v = W'($urandom_range(0, 20));
      default: v = W'({$urandom, $urandom});
    endcase
    return v;
  endfunction

  // exp_lat < 0 accepts either the early-out or the full divide latency.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic dit_v, input logic [W-1:0] exp_res, input int exp_lat,
                        input int hold, input logic kill_at_accept, input string tag);
    int           lat;
    logic [W-1:0] held;
    @(negedge clk);
    in_valid  = 1'b1;
    op_in     = op;
    op_a      = a;
    op_b      = b;
    dit       = dit_v;
    kill      = kill_at_accept;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill     = 1'b0;
    op_in    = 3'($urandom);
    op_a     = W'({$urandom, $urandom});
    op_b     = W'({$urandom, $urandom});
    dit      = 1'($urandom);
    lat      = 1;
    while (!out_valid && lat < DIV_LAT + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_lat > 0) check_value({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    else check_value({tag, "_lat"}, 64'(lat == 2 || lat == DIV_LAT), 64'(1));
    check_value({tag, "_res"}, 64'(result), 64'(exp_res));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_value({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      check_value({tag, "_hold_ready"}, 64'(in_ready), 64'(0));
      check_value({tag, "_hold_res"}, 64'(result), 64'(held));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_value({tag, "_idle"}, 64'(in_ready), 64'(1));
    $display("txn %s op=%0d a=%h b=%h dit=%0d res=%h exp=%h lat=%0d",
             tag, op, a, b, dit_v, held, exp_res, lat);
  endtask

  initial begin
    logic [W-1:0] min_v, ones, a, b;
    logic [2:0]   op;
    logic         d;
    int           el;
    logic         seen;
    min_v = '0;
    min_v[W-1] = 1'b1;
    ones = '1;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_in_ready", 64'(in_ready), 64'(1));
    check_value("rst_out_valid", 64'(out_valid), 64'(0));
    check_value("rst_result", 64'(result), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op(OP_MULH,   min_v, min_v, 1'b0, min_v >> 1, MUL_LAT, 0, 1'b0, "mulh_min");
    run_op(OP_MUL,    min_v, min_v, 1'b0, '0,         MUL_LAT, 0, 1'b0, "mul_min");
    run_op(OP_MULHSU, ones,  ones,  1'b0, ones,       MUL_LAT, 0, 1'b0, "mulhsu_m1");
    run_op(OP_MULHU,  ones,  ones,  1'b0, ones - W'(1), MUL_LAT, 0, 1'b0, "mulhu_m1");
    run_op(OP_DIV,    min_v, ones,  1'b0, min_v,      DIV_LAT, 0, 1'b0, "div_ovf");
    run_op(OP_REM,    min_v, ones,  1'b0, '0,         DIV_LAT, 0, 1'b0, "rem_ovf");
    run_op(OP_DIVU,   W'(7), '0,    1'b0, ones,       2,       0, 1'b0, "divu_z");
    run_op(OP_REM,    W'(-7), '0,   1'b1, W'(-7),     DIV_LAT, 0, 1'b0, "rem_z_dit");
    run_op(OP_DIV,    W'(-7), W'(2), 1'b0, W'(-3),    DIV_LAT, 5, 1'b0, "div_m7");
    run_op(OP_REM,    W'(-7), W'(2), 1'b0, W'(-1),    DIV_LAT, 5, 1'b0, "rem_m7");
    run_op(OP_MUL,    W'(6), W'(7), 1'b0, W'(42),     MUL_LAT, 0, 1'b1, "kill_idle");

    // Kill a divide in flight: the result must never appear.
    @(negedge clk);
    in_valid = 1'b1;
    op_in    = OP_DIV;
    op_a     = W'($urandom);
    op_b     = W'(5);
    dit      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < DIV_LAT + 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_value("kill_no_valid", 64'(seen), 64'(0));
    check_value("kill_ready", 64'(in_ready), 64'(1));
    $display("txn kill_div seen_valid=%0d", seen);
    run_op(OP_MUL, W'(3), W'(5), 1'b0, W'(15), MUL_LAT, 0, 1'b0, "mul_after_kill");

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    in_valid = 1'b1;
    op_in    = OP_MULHU;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_value("midrst_valid", 64'(out_valid), 64'(0));
    check_value("midrst_ready", 64'(in_ready), 64'(1));
    check_value("midrst_result", 64'(result), 64'(0));
    $display("txn mid_op_reset");
    run_op(OP_MULH, W'(-3), W'(5), 1'b0, W'(-1), MUL_LAT, 0, 1'b0, "mulh_after_rst");

    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      d  = 1'($urandom_range(0, 1));
      if (op < OP_DIV)                        el = MUL_LAT;
      else if (d)                             el = DIV_LAT;
      else if (b == '0)                       el = 2;
      else if (op == OP_DIVU || op == OP_REMU) el = (a < b) ? 2 : DIV_LAT;
      else                                    el = -1;
      run_op(op, a, b, d, model(op, a, b), el, $urandom_range(0, 2), 1'b0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
